// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receive engine.
// Synchronizes serial_in, detects a start edge, then samples each bit at
// its centre using a latched bit period. Frames of 5..8 data bits, LSB
// first, land in rx_data with data_ready / overrun_error / framing_error.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synced line
// START | counting half a bit, then confirming the start bit is still low
// DATA  | sampling one data bit every bit period
// STOP  | sampling the stop bit one period after the last data bit
// LOAD  | single cycle that commits the frame to the outputs
module uart_rx_core #(
  parameter int unsigned MIN_PERIOD = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        serial_in,
  input  logic [13:0] bit_period,
  input  logic [3:0]  data_size,
  input  logic        data_read,
  output logic [7:0]  rx_data,
  output logic        data_ready,
  output logic        overrun_error,
  output logic        framing_error,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    LOAD  = 3'd4
  } state_t;

  localparam logic [13:0] MIN_P = 14'(MIN_PERIOD);

  state_t      state;
  state_t      state_nxt;

  logic        sync_a;
  logic        sync_b;
  logic        line_prev;

  logic [13:0] period_q;
  logic [3:0]  size_q;
  logic [13:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        stop_bit;

  logic [13:0] period_eff;
  logic [3:0]  size_eff;
  logic        start_det;
  logic        tick;
  logic        last_bit;
  logic        good_load;
  logic        bad_load;

  // Register-block values are only trusted at the start edge; out-of-range
  // values are folded to safe defaults here.
  always_comb begin
    period_eff = (bit_period < MIN_P) ? MIN_P : bit_period;
    size_eff   = ((data_size >= 4'd5) && (data_size <= 4'd8)) ? data_size : 4'd8;
  end

  // Decode of the timing/sample events that drive the state machine.
  always_comb begin
    start_det = line_prev & ~sync_b & (state == IDLE);
    tick      = (cnt == 14'd0);
    last_bit  = (bit_cnt == (size_q - 4'd1));
    good_load = (state == LOAD) & stop_bit;
    bad_load  = (state == LOAD) & ~stop_bit;
  end

  // Two-flop synchronizer plus the edge-detect flop; all idle high.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      sync_a    <= 1'b1;
      sync_b    <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_a    <= serial_in;
      sync_b    <= sync_a;
      line_prev <= sync_b;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = sync_b ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && last_bit) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame configuration is captured once per frame at the start edge.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      period_q <= 14'd0;
      size_q   <= 4'd0;
    end else if (start_det) begin
      period_q <= period_eff;
      size_q   <= size_eff;
    end
  end

  // Bit-time down-counter: half a period to the start-bit centre, then a
  // full period between every subsequent sample.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cnt <= 14'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_det) begin
            cnt <= (period_eff >> 1) - 14'd1;
          end
        end
        START, DATA, STOP: begin
          if (tick) begin
            cnt <= period_q - 14'd1;
          end else begin
            cnt <= cnt - 14'd1;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
    end else if (tick) begin
      if (state == START) begin
        bit_cnt <= 4'd0;
      end else if (state == DATA) begin
        bit_cnt <= bit_cnt + 4'd1;
        shift   <= {sync_b, shift[7:1]};
      end
    end
  end

  // Stop-bit sample, held for the LOAD decision.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      stop_bit <= 1'b0;
    end else if ((state == STOP) && tick) begin
      stop_bit <= sync_b;
    end
  end

  // Received data: a short frame sits right-justified with zeros above it.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      rx_data <= 8'h00;
    end else if (good_load) begin
      rx_data <= shift >> (4'd8 - size_q);
    end
  end

  // Status flags. A good frame landing in the same cycle as data_read wins:
  // data_ready stays set and the read clears any overrun.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (good_load) begin
      data_ready    <= 1'b1;
      overrun_error <= data_read ? 1'b0 : (overrun_error | data_ready);
    end else if (data_read) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

  // Framing error reflects only the most recent frame.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      framing_error <= 1'b0;
    end else if (start_det) begin
      framing_error <= 1'b0;
    end else if (bad_load) begin
      framing_error <= 1'b1;
    end
  end

  // Busy indication straight from the state.
  always_comb begin
    rx_busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed plus randomized frames against a frame-level
// reference model of the receiver's visible registers.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        serial_in;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        data_read;
  logic [7:0]  rx_data;
  logic        data_ready;
  logic        overrun_error;
  logic        framing_error;
  logic        rx_busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_data;
  logic       m_ready;
  logic       m_ovr;
  logic       m_fe;

  uart_rx_core #(.MIN_PERIOD(10)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .bit_period   (bit_period),
    .data_size    (data_size),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".data_ready"}, 32'(data_ready), 32'(m_ready));
    check({tag, ".overrun"}, 32'(overrun_error), 32'(m_ovr));
    check({tag, ".framing"}, 32'(framing_error), 32'(m_fe));
    check({tag, ".busy"}, 32'(rx_busy), 32'd0);
  endtask

  function automatic int eff_p(input int bp);
    return (bp < 10) ? 10 : bp;
  endfunction

  function automatic int eff_n(input int ds);
    return (ds >= 5 && ds <= 8) ? ds : 8;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drives one frame with bit time pb. The LOAD cycle is predicted from the
  // sampling rules: the start edge is seen 3 edges after the line drops and
  // the stop bit is sampled floor(P/2)+(N+1)*P after that.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int pb,
                            input bit read_at_load);
    int p;
    int n;
    int total;
    int read_c;
    logic [7:0] mask;
    p      = eff_p(int'(bit_period));
    n      = eff_n(int'(data_size));
    total  = (n + 2) * pb;
    read_c = 3 + p / 2 + (n + 1) * p;
    mask   = 8'((1 << n) - 1);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (c < pb) serial_in = 1'b0;
      else if (c < (n + 1) * pb) serial_in = data[(c / pb) - 1];
      else serial_in = stop;
      data_read = read_at_load && (c == read_c);
      if (c == 2 * pb) begin
        check("mid.busy", 32'(rx_busy), 32'd1);
        check("mid.framing_clr", 32'(framing_error), 32'd0);
      end
    end
    @(negedge clk);
    serial_in = 1'b1;
    data_read = 1'b0;
    if (stop) begin
      m_ovr   = read_at_load ? 1'b0 : (m_ovr | m_ready);
      m_ready = 1'b1;
      m_data  = data & mask;
    end else if (read_at_load) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    m_fe = ~stop;
  endtask

  initial begin
    serial_in  = 1'b1;
    data_read  = 1'b0;
    bit_period = 14'd10;
    data_size  = 4'd8;
    n_rst      = 1'b1;
    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    idle(3);
    check_all("reset");
    n_rst = 1'b0;
    idle(5);

    // good 8-bit frame
    send_frame(8'hA5, 1'b1, 10, 1'b0);
    check_all("good_a5");
    check("good_a5.value", 32'(rx_data), 32'h0A5);
    read_pulse();
    check_all("read1");

    // 5-bit frame, upper sent bits must not appear
    data_size = 4'd5;
    send_frame(8'hFB, 1'b1, 10, 1'b0);
    check_all("short5");
    check("short5.value", 32'(rx_data), 32'h01B);

    // illegal size behaves as 8, and overruns the unread 5-bit frame
    data_size = 4'd3;
    send_frame(8'h96, 1'b1, 10, 1'b0);
    check_all("size3");
    read_pulse();

    // framing error keeps data, next start clears the flag
    data_size = 4'd8;
    send_frame(8'h5A, 1'b1, 10, 1'b0);
    send_frame(8'h3C, 1'b0, 10, 1'b0);
    check_all("framing");
    read_pulse();
    send_frame(8'h11, 1'b1, 10, 1'b0);
    send_frame(8'h22, 1'b1, 10, 1'b0);
    check_all("overrun");
    check("overrun.flag", 32'(overrun_error), 32'd1);
    read_pulse();
    check_all("overrun_clr");

    // 3-cycle glitch with P=20
    bit_period = 14'd20;
    send_frame(8'h77, 1'b1, 20, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      serial_in = (c < 3) ? 1'b0 : 1'b1;
      if (c == 5) check("glitch.busy", 32'(rx_busy), 32'd1);
    end
    check_all("glitch");

    // clamp: bit_period=4 runs at 10-cycle bits
    bit_period = 14'd4;
    send_frame(8'hC3, 1'b1, 10, 1'b0);
    check_all("clamp");

    // data_read in the LOAD cycle
    bit_period = 14'd10;
    read_pulse();
    send_frame(8'h4E, 1'b1, 10, 1'b0);
    send_frame(8'hE4, 1'b1, 10, 1'b1);
    check_all("read_at_load");

    // reset during DATA
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      serial_in = (c < 10) ? 1'b0 : 1'b1;
    end
    #2 n_rst = 1'b1;
    #1;
    m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    check_all("reset_mid");
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    idle(4);
    send_frame(8'h3A, 1'b1, 10, 1'b0);
    check_all("after_reset");

    // randomized frames
    for (int i = 0; i < 14; i++) begin
      int bp;
      bp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 40));
      bit_period = 14'(bp);
      data_size  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) read_pulse();
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), eff_p(bp),
                 ($urandom_range(0, 3) == 0));
      check_all("rand");
      idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial-receive engine directly upstream of the UART APB slave register block.
- Oversamples `serial_in` with a runtime-programmable bit period and frame size, then assembles LSB-first frames of 5–8 data bits.
- Delivers each received byte together with `data_ready`, `overrun_error` and `framing_error`.
- Consumes `data_read`, `data_size` and `bit_period` from the register block.

Parameters:
- MIN_PERIOD, 10: smallest accepted bit period in clk cycles. Smaller `bit_period` values are treated as MIN_PERIOD.

Ports:
- clk  input  1  system clock; all flops on rising edge
- n_rst  input  1  asynchronous reset, active-high (1 = reset asserted)
- serial_in  input  1  asynchronous serial line, idle high
- bit_period  input  14  clk cycles per bit
- data_size  input  4  data bits per frame; legal values 5..8
- data_read  input  1  one-cycle pulse: consumer has taken rx_data
- rx_data  output  8  last good received data, zero-extended
- data_ready  output  1  unread data present in rx_data
- overrun_error  output  1  a good frame overwrote unread data
- framing_error  output  1  the last frame's stop bit sampled 0
- rx_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, n_rst=1):
  - state=IDLE; both synchronizer flops and the edge-detect flop =1.
  - Shift register and counters =0.
  - Outputs: rx_data=8'h00, data_ready=0, overrun_error=0, framing_error=0, rx_busy=0.
  - Reset mid-frame abandons the frame immediately; no outputs update from it.
- Input path:
  - 2-flop synchronizer, then one edge-detect flop.
  - Start detect = previous synced 1, current synced 0, and only while in IDLE.
- Latching at start detect (cycle T):
  - Latch `bit_period` as P: clamped to MIN_PERIOD if smaller.
  - Latch `data_size` as N: values 0..4 and 9..15 are treated as 8.
  - Register inputs may change mid-frame without effect.
  - framing_error clears to 0 at T.
- State machine: IDLE -> START -> DATA -> STOP -> LOAD -> IDLE.
- START:
  - Counts floor(P/2) cycles, then samples the synced line.
  - Sample 1 (false start/glitch): return to IDLE, no output change.
  - Sample 0: enter DATA with bit counter = 0.
- DATA:
  - Samples every P cycles.
  - Each sample shifts into bit 7 of an 8-bit right-shift register.
  - After N samples, go to STOP.
- STOP: samples once, P cycles after the last data bit.
- Sample instants: data bit k (0-based) at T+floor(P/2)+(k+1)*P; stop bit at T+floor(P/2)+(N+1)*P.
- LOAD (one cycle); outputs change on the clock edge ending LOAD:
  - Stop=1, good frame:
    - rx_data <= shift >> (8-N), so the upper 8-N bits are 0.
    - data_ready <= 1.
    - overrun_error <= 1 if data_ready was already 1 and data_read is not asserted in this cycle; otherwise unchanged.
  - Stop=0, bad frame:
    - framing_error <= 1.
    - rx_data, data_ready and overrun_error unchanged.
- data_read (any state): clears data_ready and overrun_error on the next edge.
  - Exception: in the LOAD cycle of a good frame, data_ready stays 1 and overrun is not set; the new frame wins.
- Back-to-back frames: a start edge may be detected in the first IDLE cycle after LOAD. A stop bit of exactly one bit time is sufficient.
- Line held low after a framing error: no new start is detected until the line returns high, because the edge detect requires 1->0.
- rx_busy is purely combinational from state.

Test Plan:
- Good frame: P=10, N=8, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> data_ready=1 and rx_data=8'hA5 one cycle after LOAD; framing_error=0; overrun_error=0.
- Short frame: N=5, send bits 1,1,0,1,1 -> rx_data=8'h1B; data_size=4'd3 behaves exactly as N=8.
- Framing error: 0x3C with stop=0 -> framing_error=1; rx_data keeps the previous value; data_ready unchanged; next start edge clears framing_error.
- Overrun: two good frames 0x11 then 0x22 with no data_read -> rx_data=8'h22, data_ready=1, overrun_error=1. A data_read pulse then clears both flags next cycle.
- Glitch and clamp:
  - A 3-cycle low pulse on serial_in with P=20 returns to IDLE, with no output change.
  - bit_period=4 receives correctly at 10-cycle bit timing.
- Reset and boundaries:
  - Asserting n_rst during DATA zeroes all outputs asynchronously; the next full frame is received correctly.
  - data_read coinciding with the LOAD cycle leaves data_ready=1 and overrun_error=0.
